alu_nbit_pipe: RTL and testbench
================================

# alu_nbit_pipe

Parametrised N-bit ALU that generalises the 1-bit AND/OR/ADD/SUB/SLT slice to a full WIDTH-bit datapath. It adds a two-stage registered pipeline with valid/ready handshakes and status flags (zero, carry, overflow). It sits between the register-read stage and the execute/writeback register of the pipelined MIPS datapath, and it can absorb writeback stalls without losing operations.

## Interface
- WIDTH, 32: operand and result width in bits; minimum 2.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts operands this cycle.
- op  in  2  00 AND, 01 OR, 10 ADD/SUB, 11 SLT.
- binv  in  1  for op 10: 0 ADD, 1 SUB. For op 11: selects signed/unsigned compare (see Configuration). Ignored for op 00 and 01.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.
- carry  out  1  adder carry-out.
- of  out  1  signed overflow.

## Operation
- Stage 1 (S1) register captures {op, binv, a_in, b_in} on an in_valid && in_ready cycle and sets s1_valid.
- Stage 2 (S2) register holds the computed result and flags. out_valid equals s2_valid.
- Adder: sum = a + (b XOR {WIDTH{sub}}) + sub, computed in WIDTH+1 bits.
  - sub = 1 for op 10 with binv=1, and for op 11.
  - carry = bit WIDTH of sum. For SUB, carry=1 means no borrow.
- of = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the inverted-or-not B. of is forced to 0 for op 00 and 01.
- carry is forced to 0 for op 00 and 01. For op 11, carry and of report the internal subtract.
- SLT signed: result = {WIDTH-1 zeros, sum[MSB] XOR of}.
- zero = (result == 0), computed on the final result, including SLT.
- S2 update condition: s2_load = s1_valid && (!s2_valid || out_ready).
- S1 advance: in_ready = !s1_valid || s2_load. in_ready is combinational on out_ready.
- Simultaneous events:
  - Accept and advance in the same cycle: S1 takes the new operands and S2 takes the old S1 contents.
  - Drain with no new input: s1_valid clears on s2_load when there is no accept.
  - out_ready with no s1_valid: s2_valid clears.
- While out_valid && !out_ready: result and flags hold stable.
- No operation is dropped or duplicated under any stall pattern.
- Reset (any cycle, including mid-stream): s1_valid=0 and s2_valid=0. All in-flight operations are discarded.
  - Outputs: out_valid=0; result=0, zero=0, carry=0, of=0.
  - in_ready is 1 from the first cycle after reset deasserts.

## Timing
- Latency: operands accepted at edge N appear with out_valid=1 after edge N+1, provided S2 is free.
- Throughput: one operation per cycle when out_ready is held high.
- Buffering: at most 2 operations in flight. With out_ready low, the block accepts 2 operations, then drops in_ready.
- The adder and compare are combinational between S1 and S2. There is no combinational path from a_in/b_in to result.

## Configuration
- ALU_SLTU_EN defined:
  - op 11 with binv=1: signed SLT.
  - op 11 with binv=0: unsigned SLTU, result LSB = !carry (borrow).
- ALU_SLTU_EN undefined: op 11 is always signed SLT and binv is ignored for op 11.

## Test plan
- Reset then basic ops, WIDTH=32, out_ready=1:
  - AND 0xF0F0_1234, 0x0FF0_FFFF -> 0x00F0_1234 two cycles after accept.
  - OR of the same operands -> 0xFFF0_FFFF.
- Arithmetic flags:
  - ADD 0x7FFF_FFFF+1 -> 0x8000_0000, of=1, carry=0.
  - ADD 0xFFFF_FFFF+1 -> 0, zero=1, carry=1, of=0.
  - SUB 5-5 -> 0, zero=1, carry=1.
- SLT:
  - signed 0xFFFF_FFFF vs 1 -> result 1.
  - 0x8000_0000 vs 0x7FFF_FFFF -> 1.
  - With ALU_SLTU_EN, binv=0: 0xFFFF_FFFF vs 1 -> 0.
- Backpressure: hold out_ready=0 and issue ops A, B, C back-to-back.
  - in_ready drops after B is accepted; result A is held stable.
  - Release out_ready: results A, B, C emerge in order, with no loss or duplication.
- Random out_ready at 50% plus random in_valid for 10k ops: the scoreboard matches a reference model for every result and flag.
- Assert rst with 2 operations in flight: on the next cycle out_valid=0 and all outputs are 0. A fresh op after reset completes with 2-cycle latency.

Source files
------------

// File: rtl/alu_nbit_pipe_if.sv
// alu_nbit_pipe_if
// Handshake and data bundle for the pipelined N-bit ALU.
//   master : operand producer / result consumer (drives operands, out_ready)
//   slave  : the ALU (drives in_ready, result and status flags)
// Signals:
//   in_valid, in_ready          operand handshake
//   op[1:0], binv, a_in, b_in   operation select and operands
//   out_valid, out_ready        result handshake
//   result, zero, carry, of     ALU result and status flags
interface alu_nbit_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic             binv;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             of;

   modport master (
      output in_valid, op, binv, a_in, b_in, out_ready,
      input  in_ready, out_valid, result, zero, carry, of
   );

   modport slave (
      input  in_valid, op, binv, a_in, b_in, out_ready,
      output in_ready, out_valid, result, zero, carry, of
   );
endinterface

// File: rtl/alu_nbit_pipe.sv
// alu_nbit_pipe
// WIDTH-bit AND/OR/ADD/SUB/SLT ALU with a two-stage valid/ready pipeline.
// S1 registers the operands, S2 registers the result and flags; the adder
// and compare sit between them, so nothing from a_in/b_in reaches result
// combinationally. Up to two operations can be in flight.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears both stages and outputs
//   bus   alu_nbit_pipe_if.slave (operand / result handshakes and flags)
// Optional feature macro: ALU_SLTU_EN
//   defined   : op 11 with binv=1 is signed SLT, binv=0 is unsigned SLTU
//   undefined : op 11 is always signed SLT, binv ignored for op 11
module alu_nbit_pipe #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   alu_nbit_pipe_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   localparam logic [1:0] OP_AND    = 2'b00;
   localparam logic [1:0] OP_OR     = 2'b01;
   localparam logic [1:0] OP_ADDSUB = 2'b10;
   localparam logic [1:0] OP_SLT    = 2'b11;

   logic             s1_valid_q, s1_valid_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic             s1_binv_q, s1_binv_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic             s2_zero_q, s2_zero_d;
   logic             s2_carry_q, s2_carry_d;
   logic             s2_of_q, s2_of_d;

   logic             s2_load;
   logic             in_ready;
   logic             accept;

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic             slt_bit;
   logic [WIDTH-1:0] alu_res;
   logic             arith;

   // Handshake: S2 frees up when empty or being consumed; S1 frees up when
   // empty or moving into S2. in_ready therefore depends on out_ready.
   always_comb begin
      s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);
      in_ready = !s1_valid_q || s2_load;
      accept   = bus.in_valid && in_ready;
   end

   // Execute: shared adder, subtract for SUB and for both compares.
   always_comb begin
      sub     = ((s1_op_q == OP_ADDSUB) && s1_binv_q) || (s1_op_q == OP_SLT);
      b_eff   = s1_b_q ^ {WIDTH{sub}};
      sum     = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      ovf     = (s1_a_q[MSB] == b_eff[MSB]) && (sum[MSB] != s1_a_q[MSB]);
`ifdef ALU_SLTU_EN
      // Unsigned less-than is a borrow out of the subtract.
      slt_bit = s1_binv_q ? (sum[MSB] ^ ovf) : !sum[WIDTH];
`else
      slt_bit = sum[MSB] ^ ovf;
`endif
      unique case (s1_op_q)
         OP_AND:    alu_res = s1_a_q & s1_b_q;
         OP_OR:     alu_res = s1_a_q | s1_b_q;
         OP_ADDSUB: alu_res = sum[WIDTH-1:0];
         default:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      endcase
      // Flags only meaningful for the adder ops; logic ops report 0.
      arith   = s1_op_q[1];
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_binv_d   = s1_binv_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_zero_d   = s2_zero_q;
      s2_carry_d  = s2_carry_q;
      s2_of_d     = s2_of_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = bus.op;
         s1_binv_d  = bus.binv;
         s1_a_d     = bus.a_in;
         s1_b_d     = bus.b_in;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      // Result and flags only change on a load, so they hold during stalls.
      if (s2_load) begin
         s2_valid_d  = 1'b1;
         s2_result_d = alu_res;
         s2_zero_d   = (alu_res == '0);
         s2_carry_d  = arith & sum[WIDTH];
         s2_of_d     = arith & ovf;
      end else if (bus.out_ready) begin
         s2_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= 2'b00;
         s1_binv_q   <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_zero_q   <= 1'b0;
         s2_carry_q  <= 1'b0;
         s2_of_q     <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_binv_q   <= s1_binv_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_zero_q   <= s2_zero_d;
         s2_carry_q  <= s2_carry_d;
         s2_of_q     <= s2_of_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.result    = s2_result_q;
   assign bus.zero      = s2_zero_q;
   assign bus.carry     = s2_carry_q;
   assign bus.of        = s2_of_q;
endmodule

// File: tb/tb_alu_nbit_pipe.sv
// Testbench for alu_nbit_pipe (WIDTH=32): directed flag/compare cases,
// backpressure ordering, random stall soak and mid-stream reset.
module tb_alu_nbit_pipe;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] r;
      logic         z;
      logic         c;
      logic         o;
   } exp_t;

   logic clk;
   logic rst;
   alu_nbit_pipe_if #(.WIDTH(W)) bus();

   alu_nbit_pipe #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   acc    = 0;
   logic lat_en = 1'b0;

   exp_t exp_q[$];
   int   cyc_q[$];
   logic lat_q[$];

   logic [W-1:0] specials [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'h8000_0001};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic c, input logic o);
      exp_t e;
      e.r = r; e.z = z; e.c = c; e.o = o;
      return e;
   endfunction

   // Reference model built from wide signed/unsigned arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic bi,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa, sb, t;
      logic [W:0] s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e  = '0;
      case (op)
         2'b00: e.r = a & b;
         2'b01: e.r = a | b;
         2'b10: begin
            if (!bi) begin
               s   = {1'b0, a} + {1'b0, b};
               e.r = s[W-1:0];
               e.c = s[W];
               t   = sa + sb;
            end else begin
               e.r = a - b;
               e.c = (a >= b);
               t   = sa - sb;
            end
            e.o = (t != longint'($signed(t[31:0])));
         end
         default: begin
            t   = sa - sb;
            e.c = (a >= b);
            e.o = (t != longint'($signed(t[31:0])));
`ifdef ALU_SLTU_EN
            e.r = bi ? W'(sa < sb) : W'(a < b);
`else
            e.r = W'(sa < sb);
`endif
         end
      endcase
      e.z = (e.r == '0);
      return e;
   endfunction

   // One clock cycle: drive inputs, observe handshakes mid-cycle, advance.
   task automatic step(input logic v, input logic [1:0] o, input logic bi,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy,
                       input logic has_e, input exp_t e);
      exp_t got_e;
      int   pc;
      logic pl;
      bus.in_valid  = v;
      bus.op        = o;
      bus.binv      = bi;
      bus.a_in      = a;
      bus.b_in      = b;
      bus.out_ready = ordy;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_output_without_op", 64'(exp_q.size()), 64'd1);
         end else begin
            got_e = exp_q.pop_front();
            pc    = cyc_q.pop_front();
            pl    = lat_q.pop_front();
            chk("result", 64'(bus.result), 64'(got_e.r));
            chk("zero",   64'(bus.zero),   64'(got_e.z));
            chk("carry",  64'(bus.carry),  64'(got_e.c));
            chk("of",     64'(bus.of),     64'(got_e.o));
            if (pl) chk("latency", 64'(cyc - pc), 64'd2);
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         exp_q.push_back(has_e ? e : model(o, bi, a, b));
         cyc_q.push_back(cyc);
         lat_q.push_back(lat_en);
         acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 2'b00, 1'b0, '0, '0, ordy, 1'b0, '0);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_no_extra_valid", 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 2'b00;
      bus.binv      = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_result",    64'(bus.result),    64'd0);
      chk("reset_flags",     64'({bus.zero, bus.carry, bus.of}), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

      // Directed ops, out_ready high, back-to-back, 2-cycle latency.
      lat_en = 1'b1;
      step(1, 2'b00, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 1, mk(32'h00F0_1234, 0, 0, 0));
      step(1, 2'b01, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 1, mk(32'hFFF0_FFFF, 0, 0, 0));
      step(1, 2'b10, 0, 32'h7FFF_FFFF, 32'h1,         1, 1, mk(32'h8000_0000, 0, 0, 1));
      step(1, 2'b10, 0, 32'hFFFF_FFFF, 32'h1,         1, 1, mk(32'h0,         1, 1, 0));
      step(1, 2'b10, 1, 32'h5,         32'h5,         1, 1, mk(32'h0,         1, 1, 0));
      step(1, 2'b11, 1, 32'hFFFF_FFFF, 32'h1,         1, 1, mk(32'h1,         0, 1, 0));
      step(1, 2'b11, 1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1, mk(32'h1,         0, 1, 1));
`ifdef ALU_SLTU_EN
      step(1, 2'b11, 0, 32'hFFFF_FFFF, 32'h1,         1, 1, mk(32'h0,         1, 1, 0));
`else
      step(1, 2'b11, 0, 32'hFFFF_FFFF, 32'h1,         1, 1, mk(32'h1,         0, 1, 0));
`endif
      drain();

      // Backpressure: A, B fill the pipe, C waits; A held stable.
      lat_en = 1'b0;
      step(1, 2'b10, 0, 32'd10, 32'd20, 0, 1, mk(32'd30, 0, 0, 0));
      step(1, 2'b10, 1, 32'd3,  32'd5,  0, 1, mk(32'hFFFF_FFFE, 0, 0, 0));
      chk("bp_in_ready_drop", 64'(bus.in_ready),  64'd0);
      chk("bp_out_valid",     64'(bus.out_valid), 64'd1);
      for (int k = 0; k < 3; k++) begin
         step(1, 2'b01, 0, 32'h100, 32'h001, 0, 1, mk(32'h101, 0, 0, 0));
         chk("bp_hold_result", 64'(bus.result),   64'd30);
         chk("bp_hold_ready",  64'(bus.in_ready), 64'd0);
      end
      step(1, 2'b01, 0, 32'h100, 32'h001, 1, 1, mk(32'h101, 0, 0, 0));
      drain();

      // Random soak against the model.
      acc = 0;
      for (int k = 0; k < 80000 && acc < 10000; k++) begin
         logic [W-1:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ra, rb, 1'($urandom_range(0, 1)), 1'b0, '0);
      end
      chk("random_ops_done", 64'(acc >= 10000), 64'd1);
      drain();

      // Reset with two ops in flight.
      step(1, 2'b01, 0, 32'h55, 32'hAA, 0, 1, mk(32'hFF, 0, 0, 0));
      step(1, 2'b10, 0, 32'h7FFF_FFFF, 32'h1, 0, 1, mk(32'h8000_0000, 0, 0, 1));
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_mid_result",    64'(bus.result),    64'd0);
      chk("rst_mid_flags",     64'({bus.zero, bus.carry, bus.of}), 64'd0);
      exp_q.delete();
      cyc_q.delete();
      lat_q.delete();
      rst = 1'b0;
      chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
      lat_en = 1'b1;
      step(1, 2'b10, 0, 32'd3, 32'd4, 1, 1, mk(32'd7, 0, 0, 0));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
